param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo.sv | 104 ++++++++++
 tb/tb_param_sync_fifo.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock parameterised FIFO with registered read data,
// occupancy count and full/empty/almost-full/almost-empty status flags.
// Optional sticky overflow/underflow flags are built when the macro
// PARAM_SYNC_FIFO_ERR_FLAGS_EN is defined.
module param_sync_fifo #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     re_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
  ,
  input  logic                     err_clr_i,
  output logic                     overflow_o,
  output logic                     underflow_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Thresholds resized to the count width so every compare is width-matched.
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_C    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              wr_acc;
  logic              rd_acc;

  // Request acceptance gated by the registered status flags.
  always_comb begin
    wr_acc = we_i && !full_o;
    rd_acc = re_i && !empty_o;
  end

  // Status flags decoded from the registered occupancy count.
  always_comb begin
    count_o        = count;
    full_o         = (count == DEPTH_C);
    empty_o        = (count == '0);
    almost_full_o  = (count >= AF_C);
    almost_empty_o = (count <= AE_C);
  end

  // Storage array; no reset, stale contents are unreachable after reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointers, occupancy count and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      data_o <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        data_o <= mem[rd_ptr];
      end
      if (wr_acc && !rd_acc) begin
        count <= count + CNT_ONE;
      end else if (rd_acc && !wr_acc) begin
        count <= count - CNT_ONE;
      end
    end
  end

`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= (we_i && full_o)  || (overflow_o  && !err_clr_i);
      underflow_o <= (re_i && empty_o) || (underflow_o && !err_clr_i);
    end
  end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: directed self-checking bench for param_sync_fifo.
// Covers the default 16x32 configuration and an 8-deep instance; the error
// flag scenario is compiled when PARAM_SYNC_FIFO_ERR_FLAGS_EN is defined.
module tb_param_sync_fifo;

  logic        clk;
  logic        rst_n;
  logic        we_i, re_i;
  logic [31:0] data_i, data_o;
  logic        full_o, empty_o, almost_full_o, almost_empty_o;
  logic [4:0]  count_o;
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
  logic        err_clr_i, overflow_o, underflow_o;
`endif

  logic        we8, re8;
  logic [15:0] din8, dout8;
  logic        full8, empty8, afull8, aempty8;
  logic [3:0]  count8;

  int errors;
  int checks;

  param_sync_fifo #(
    .DATA_W(32), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .we_i(we_i), .data_i(data_i), .re_i(re_i), .data_o(data_o),
    .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .count_o(count_o)
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    , .err_clr_i(err_clr_i), .overflow_o(overflow_o), .underflow_o(underflow_o)
`endif
  );

  param_sync_fifo #(
    .DATA_W(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .we_i(we8), .data_i(din8), .re_i(re8), .data_o(dout8),
    .full_o(full8), .empty_o(empty8),
    .almost_full_o(afull8), .almost_empty_o(aempty8),
    .count_o(count8)
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    , .err_clr_i(1'b0), .overflow_o(), .underflow_o()
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock on the default instance; outputs are settled 1 time unit later.
  task automatic cyc(input logic we, input logic [31:0] d, input logic re);
    we_i = we; data_i = d; re_i = re;
    @(posedge clk); #1;
    we_i = 1'b0; re_i = 1'b0;
  endtask

  task automatic cyc8(input logic we, input logic [15:0] d, input logic re);
    we8 = we; din8 = d; re8 = re;
    @(posedge clk); #1;
    we8 = 1'b0; re8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (count_o !== 5'd0 || empty_o !== 1'b1 || full_o !== 1'b0 ||
        almost_empty_o !== 1'b1 || almost_full_o !== 1'b0 || data_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: count=%0d empty=%b full=%b ae=%b af=%b data=%h, need 0 1 0 1 0 0",
               count_o, empty_o, full_o, almost_empty_o, almost_full_o, data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 32'(i), 1'b0);
      checks++;
      if (count_o !== 5'(i + 1)) begin
        errors++;
        $display("FAIL fill_count[%0d]: got %0d need %0d", i, count_o, i + 1);
      end
    end
    checks++;
    if (full_o !== 1'b1 || count_o !== 5'd16) begin
      errors++;
      $display("FAIL fill_full: full=%b count=%0d, need 1 16", full_o, count_o);
    end
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if (count_o !== 5'd16 || full_o !== 1'b1) begin
      errors++;
      $display("FAIL write_when_full: count=%0d full=%b, need 16 1", count_o, full_o);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 32'd0, 1'b1);
      checks++;
      if (data_o !== 32'(i)) begin
        errors++;
        $display("FAIL drain_data[%0d]: got %h need %h", i, data_o, i);
      end
    end
    checks++;
    if (empty_o !== 1'b1 || count_o !== 5'd0) begin
      errors++;
      $display("FAIL drain_empty: empty=%b count=%0d, need 1 0", empty_o, count_o);
    end
    cyc(1'b0, 32'd0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0);
    checks++;
    if (data_o !== 32'h0000_000F || count_o !== 5'd0) begin
      errors++;
      $display("FAIL data_hold: data=%h count=%0d, need 0000000f 0", data_o, count_o);
    end
  endtask

  task automatic test_almost_flags();
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 32'h100 + 32'(i), 1'b0);
      checks++;
      if (almost_empty_o !== (i <= 2) || almost_full_o !== (i >= 14)) begin
        errors++;
        $display("FAIL almost_flags[count=%0d]: ae=%b af=%b, need %b %b",
                 i, almost_empty_o, almost_full_o, (i <= 2), (i >= 14));
      end
    end
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 32'd0, 1'b1);
    end
    checks++;
    if (data_o !== 32'h110 || empty_o !== 1'b1) begin
      errors++;
      $display("FAIL almost_drain: data=%h empty=%b, need 00000110 1", data_o, empty_o);
    end
  endtask

  task automatic test_simultaneous();
    cyc(1'b1, 32'h55, 1'b1);
    checks++;
    if (count_o !== 5'd1 || data_o !== 32'h110) begin
      errors++;
      $display("FAIL rw_when_empty: count=%0d data=%h, need 1 00000110", count_o, data_o);
    end
    for (int i = 1; i < 16; i++) begin
      cyc(1'b1, 32'h200 + 32'(i), 1'b0);
    end
    // Write is refused because full_o is high at the edge; the read proceeds.
    cyc(1'b1, 32'hBAD, 1'b1);
    checks++;
    if (count_o !== 5'd15 || data_o !== 32'h55 || full_o !== 1'b0) begin
      errors++;
      $display("FAIL rw_when_full: count=%0d data=%h full=%b, need 15 00000055 0",
               count_o, data_o, full_o);
    end
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 32'd0, 1'b1);
      checks++;
      if (data_o !== 32'h200 + 32'(i)) begin
        errors++;
        $display("FAIL rw_full_order[%0d]: got %h need %h", i, data_o, 32'h200 + 32'(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      cyc8(1'b1, 16'(i), 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      cyc8(1'b1, 16'(i + 4), 1'b1);
      checks++;
      if (count8 !== 4'd4 || dout8 !== 16'(i)) begin
        errors++;
        $display("FAIL b2b[%0d]: count=%0d data=%h, need 4 %h", i, count8, dout8, 16'(i));
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc8(1'b0, 16'd0, 1'b1);
      checks++;
      if (dout8 !== 16'(i + 20)) begin
        errors++;
        $display("FAIL b2b_drain[%0d]: got %h need %h", i, dout8, 16'(i + 20));
      end
    end
    checks++;
    if (empty8 !== 1'b1 || aempty8 !== 1'b1 || afull8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: empty=%b ae=%b af=%b, need 1 1 0", empty8, aempty8, afull8);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 32'hA0 + 32'(i), 1'b0);
    end
    cyc(1'b0, 32'd0, 1'b1);
    checks++;
    if (count_o !== 5'd7 || data_o !== 32'hA0) begin
      errors++;
      $display("FAIL pre_reset: count=%0d data=%h, need 7 000000a0", count_o, data_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count_o !== 5'd0 || empty_o !== 1'b1 || data_o !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: count=%0d empty=%b data=%h, need 0 1 0", count_o, empty_o, data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 32'h77, 1'b0);
    cyc(1'b0, 32'd0, 1'b1);
    checks++;
    if (data_o !== 32'h77 || empty_o !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_first: data=%h empty=%b, need 00000077 1", data_o, empty_o);
    end
  endtask

`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
  task automatic test_err_flags();
    cyc(1'b0, 32'd0, 1'b1);
    checks++;
    if (underflow_o !== 1'b1 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL underflow_set: uf=%b of=%b, need 1 0", underflow_o, overflow_o);
    end
    cyc(1'b0, 32'd0, 1'b0);
    checks++;
    if (underflow_o !== 1'b1) begin
      errors++;
      $display("FAIL underflow_sticky: got %b need 1", underflow_o);
    end
    err_clr_i = 1'b1;
    cyc(1'b0, 32'd0, 1'b0);
    err_clr_i = 1'b0;
    checks++;
    if (underflow_o !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear: got %b need 0", underflow_o);
    end
    err_clr_i = 1'b1;
    cyc(1'b0, 32'd0, 1'b1);
    err_clr_i = 1'b0;
    checks++;
    if (underflow_o !== 1'b1) begin
      errors++;
      $display("FAIL set_wins_clear: got %b need 1", underflow_o);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 32'(i), 1'b0);
    end
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL overflow_idle: got %b need 0", overflow_o);
    end
    cyc(1'b1, 32'hFF, 1'b0);
    checks++;
    if (overflow_o !== 1'b1 || count_o !== 5'd16) begin
      errors++;
      $display("FAIL overflow_set: of=%b count=%0d, need 1 16", overflow_o, count_o);
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    we_i = 1'b0; re_i = 1'b0; data_i = '0;
    we8 = 1'b0; re8 = 1'b0; din8 = '0;
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    err_clr_i = 1'b0;
`endif
    test_reset();
    test_fill_drain();
    test_almost_flags();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    test_err_flags();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
